// File: rtl/line_fill_responder.sv
// Backing-memory responder for data-cache line fills and writebacks.
// Accepts one line request at a time. A read waits LATENCY cycles and then
// streams LINEWORDS beats. A write absorbs LINEWORDS beats, waits LATENCY
// cycles and then returns a single acknowledge beat.
module line_fill_responder #(
  parameter int ADDRW     = 16,
  parameter int LINEWORDS = 4,
  parameter int LATENCY   = 3,
  parameter int DEPTH     = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [ADDRW-1:0] req_addr,
  input  logic             wd_valid,
  output logic             wd_ready,
  input  logic [31:0]      wd_data,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  output logic             rsp_last,
  output logic             rsp_write,
  output logic             busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int BW = $clog2(LINEWORDS);
  localparam int LW = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RWAIT  = 3'd1,
    RBURST = 3'd2,
    WDATA  = 3'd3,
    WWAIT  = 3'd4,
    WACK   = 3'd5
  } state_t;

  state_t        state_q;
  logic [BW-1:0] beat_q;
  logic [LW-1:0] lat_q;
  logic [AW-1:0] base_q;

  logic [31:0]   mem_q [DEPTH];

  // Line base from the byte address: drop the byte offset, align to the line,
  // keep only the bits that index storage (so addresses wrap modulo DEPTH).
  logic [ADDRW+AW+1:0] addr_ext;
  logic [AW-1:0]       base_d;
  logic                unused_addr;
  logic [AW-1:0]       mem_addr;
  logic                last_beat;

  assign addr_ext    = {(AW + 2)'(0), req_addr};
  assign base_d      = addr_ext[AW+1:2] & ~AW'(LINEWORDS - 1);
  assign unused_addr = ^{addr_ext[1:0], addr_ext[ADDRW+AW+1:AW+2]};

  // Beat k touches word base+k; the AW-bit sum wraps the top of storage to 0.
  assign mem_addr  = base_q + AW'(beat_q);
  assign last_beat = (beat_q == BW'(LINEWORDS - 1));

  // Handshake readiness and response fields are decoded from registered state
  // only, so they stay stable for as long as a response is stalled.
  assign req_ready = (state_q == IDLE);
  assign wd_ready  = (state_q == WDATA);
  assign rsp_valid = (state_q == RBURST) || (state_q == WACK);
  assign rsp_write = (state_q == WACK);
  assign rsp_last  = ((state_q == RBURST) && last_beat) || (state_q == WACK);
  assign rsp_data  = (state_q == RBURST) ? mem_q[mem_addr] : 32'd0;
  assign busy      = (state_q != IDLE);

  // Request/latency/burst sequencing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      beat_q  <= '0;
      lat_q   <= '0;
      base_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            base_q <= base_d;
            beat_q <= '0;
            lat_q  <= LW'(LATENCY);
            if (req_write)        state_q <= WDATA;
            else if (LATENCY > 0) state_q <= RWAIT;
            else                  state_q <= RBURST;
          end
        end
        RWAIT: begin
          lat_q <= lat_q - LW'(1);
          if (lat_q == LW'(1)) state_q <= RBURST;
        end
        RBURST: begin
          if (rsp_ready) begin
            beat_q <= beat_q + BW'(1);
            if (last_beat) state_q <= IDLE;
          end
        end
        WDATA: begin
          if (wd_valid) begin
            beat_q <= beat_q + BW'(1);
            if (last_beat) begin
              lat_q   <= LW'(LATENCY);
              state_q <= (LATENCY > 0) ? WWAIT : WACK;
            end
          end
        end
        WWAIT: begin
          lat_q <= lat_q - LW'(1);
          if (lat_q == LW'(1)) state_q <= WACK;
        end
        WACK: begin
          if (rsp_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Storage is committed one beat at a time and is deliberately not reset.
  always_ff @(posedge clk) begin
    if ((state_q == WDATA) && wd_valid) mem_q[mem_addr] <= wd_data;
  end

endmodule

// File: tb/tb_line_fill_responder.sv
// Directed bench for line_fill_responder: default build plus a LATENCY=0 build.
module tb_line_fill_responder;

  logic        clk;
  logic        rst;

  logic        req_valid, req_ready, req_write;
  logic [15:0] req_addr;
  logic        wd_valid, wd_ready;
  logic [31:0] wd_data;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_last, rsp_write, busy;

  logic        z_req_valid, z_req_ready, z_req_write;
  logic [15:0] z_req_addr;
  logic        z_wd_valid, z_wd_ready;
  logic [31:0] z_wd_data;
  logic        z_rsp_valid, z_rsp_ready;
  logic [31:0] z_rsp_data;
  logic        z_rsp_last, z_rsp_write, z_busy;

  int checks = 0;
  int errors = 0;

  line_fill_responder u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write), .req_addr(req_addr),
    .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_last(rsp_last), .rsp_write(rsp_write), .busy(busy)
  );

  line_fill_responder #(.LATENCY(0)) u_l0 (
    .clk(clk), .rst(rst),
    .req_valid(z_req_valid), .req_ready(z_req_ready), .req_write(z_req_write), .req_addr(z_req_addr),
    .wd_valid(z_wd_valid), .wd_ready(z_wd_ready), .wd_data(z_wd_data),
    .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready), .rsp_data(z_rsp_data),
    .rsp_last(z_rsp_last), .rsp_write(z_rsp_write), .busy(z_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(input logic [15:0] addr, input logic wr);
    int n;
    n = 0;
    req_addr  = addr;
    req_write = wr;
    req_valid = 1'b1;
    while (!req_ready && n < 20) begin
      tick();
      n++;
    end
    check("req_ready_before_accept", req_ready, 1'b1);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic write_line(input logic [15:0] addr, input logic [31:0] d0, d1, d2, d3);
    logic [31:0] d [4];
    int n;
    d = '{d0, d1, d2, d3};
    do_req(addr, 1'b1);
    for (int k = 0; k < 4; k++) begin
      wd_valid = 1'b1;
      wd_data  = d[k];
      check("wd_ready", wd_ready, 1'b1);
      tick();
    end
    wd_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 20) begin
      tick();
      n++;
    end
    check("wack_latency", n, 3);
    check("wack_write", rsp_write, 1'b1);
    check("wack_last", rsp_last, 1'b1);
    check("wack_data", rsp_data, 32'd0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("wack_idle", busy, 1'b0);
  endtask

  task automatic read_line(input logic [15:0] addr, input logic [31:0] e0, e1, e2, e3,
                           input int stall_beat, input int stall_n);
    logic [31:0] e [4];
    int n;
    e = '{e0, e1, e2, e3};
    do_req(addr, 1'b0);
    n = 0;
    while (!rsp_valid && n < 20) begin
      tick();
      n++;
    end
    check("rd_latency", n, 3);
    for (int k = 0; k < 4; k++) begin
      if (k == stall_beat) begin
        rsp_ready = 1'b0;
        for (int s = 0; s < stall_n; s++) begin
          tick();
          check("stall_valid", rsp_valid, 1'b1);
          check("stall_data", rsp_data, e[k]);
          check("stall_last", rsp_last, (k == 3));
        end
      end
      rsp_ready = 1'b1;
      check("rd_valid", rsp_valid, 1'b1);
      check("rd_data", rsp_data, e[k]);
      check("rd_last", rsp_last, (k == 3));
      check("rd_write", rsp_write, 1'b0);
      tick();
    end
    rsp_ready = 1'b0;
    check("rd_idle", busy, 1'b0);
  endtask

  initial begin
    int n;
    int rej_ok;
    rst = 1'b1;
    req_valid = 0; req_write = 0; req_addr = '0; wd_valid = 0; wd_data = '0; rsp_ready = 0;
    z_req_valid = 0; z_req_write = 0; z_req_addr = '0; z_wd_valid = 0; z_wd_data = '0; z_rsp_ready = 0;
    tick();
    tick();
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_wd_ready", wd_ready, 1'b0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_last", rsp_last, 1'b0);
    check("rst_rsp_write", rsp_write, 1'b0);
    check("rst_rsp_data", rsp_data, 32'd0);
    check("rst_busy", busy, 1'b0);
    rst = 1'b0;
    tick();

    // Write then read from inside the line (0x4C aligns to 0x40).
    write_line(16'h0040, 32'h11, 32'h22, 32'h33, 32'h44);
    read_line(16'h004C, 32'h11, 32'h22, 32'h33, 32'h44, -1, 0);

    // Backpressure on beat 1 for two cycles.
    read_line(16'h004C, 32'h11, 32'h22, 32'h33, 32'h44, 1, 2);

    // Wrap at the top of storage: 0x1000 is word 1024, i.e. word 0.
    write_line(16'h0000, 32'hA0, 32'hA1, 32'hA2, 32'hA3);
    write_line(16'h0FF0, 32'hF0, 32'hF1, 32'hF2, 32'hF3);
    read_line(16'h1000, 32'hA0, 32'hA1, 32'hA2, 32'hA3, -1, 0);
    read_line(16'h0FF0, 32'hF0, 32'hF1, 32'hF2, 32'hF3, -1, 0);

    // Busy rejection: request held high across a whole read.
    req_addr = 16'h0040; req_write = 1'b0; req_valid = 1'b1;
    tick();
    rsp_ready = 1'b1;
    n = 0;
    rej_ok = 1;
    while (busy && n < 30) begin
      if (req_ready) rej_ok = 0;
      tick();
      n++;
    end
    check("busy_rej_ready_low", rej_ok, 1);
    check("busy_rej_duration", n, 7);
    check("busy_rej_idle_ready", req_ready, 1'b1);
    tick();
    check("busy_rej_second_accept", busy, 1'b1);
    req_valid = 1'b0;
    n = 0;
    while (busy && n < 30) begin
      tick();
      n++;
    end
    check("busy_rej_drain", busy, 1'b0);
    rsp_ready = 1'b0;

    // Reset in the middle of a write burst.
    write_line(16'h0080, 32'hAA, 32'hBB, 32'hCC, 32'hDD);
    do_req(16'h0080, 1'b1);
    wd_valid = 1'b1; wd_data = 32'h01;
    tick();
    wd_data = 32'h02;
    tick();
    wd_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_rsp_valid", rsp_valid, 1'b0);
    check("midrst_req_ready", req_ready, 1'b1);
    tick();
    rst = 1'b0;
    tick();
    read_line(16'h0080, 32'h01, 32'h02, 32'hCC, 32'hDD, -1, 0);

    // LATENCY=0 build: write then read with no idle cycles.
    z_req_addr = 16'h0000; z_req_write = 1'b1; z_req_valid = 1'b1;
    tick();
    z_req_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      z_wd_valid = 1'b1;
      z_wd_data  = 32'h50 + k;
      check("l0_wd_ready", z_wd_ready, 1'b1);
      tick();
    end
    z_wd_valid = 1'b0;
    check("l0_wack_now", z_rsp_valid, 1'b1);
    check("l0_wack_write", z_rsp_write, 1'b1);
    check("l0_wack_last", z_rsp_last, 1'b1);
    z_rsp_ready = 1'b1;
    tick();
    z_rsp_ready = 1'b0;
    z_req_addr = 16'h0008; z_req_write = 1'b0; z_req_valid = 1'b1;
    tick();
    z_req_valid = 1'b0;
    check("l0_rd_now", z_rsp_valid, 1'b1);
    z_rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("l0_rd_data", z_rsp_data, 32'h50 + k);
      check("l0_rd_last", z_rsp_last, (k == 3));
      tick();
    end
    z_rsp_ready = 1'b0;
    check("l0_rd_idle", z_busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
